// File: rtl/tcp_ack_scheduler.sv
// ---------------------------------------------------------------------------
// tcp_ack_scheduler
//
// Decides when the TCP receive path emits an ACK and what acknowledgement
// number and advertised window the ACK carries.  Supports delayed ACK with a
// cycle-count timeout, ACK-every-Nth-segment, immediate ACK on out-of-order
// arrival or FIN, and window-update ACKs.  Requests are handed to the TX
// engine on a valid/ready handshake and held stable until accepted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            connection established; low abandons and clears state
//   seg_rx            pulse: one in-order segment accepted
//   seg_ooo           pulse: out-of-order segment arrived
//   fin_rx            pulse: FIN received
//   ack_out[31:0]     next expected sequence number (reorder buffer)
//   window_size[31:0] free bytes in the reorder buffer
//   ack_done          pulse: reorder buffer drained all in-order bytes
//   ack_req_valid     ACK request to the TX engine
//   ack_req_ready     TX engine accepts the request
//   ack_req_seq[31:0] acknowledgement number (includes +1 for FIN)
//   ack_req_win[W-1:0] advertised window (clamped to WIN_BITS)
//   ack_req_fin       request acknowledges a FIN
// ---------------------------------------------------------------------------
module tcp_ack_scheduler #(
   parameter int unsigned DELAY_CYCLES      = 1000,
   parameter int unsigned SEGS_PER_ACK      = 2,
   parameter int unsigned WIN_UPDATE_THRESH = 4,
   parameter int unsigned WIN_BITS          = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                seg_rx,
   input  logic                seg_ooo,
   input  logic                fin_rx,
   input  logic [31:0]         ack_out,
   input  logic [31:0]         window_size,
   input  logic                ack_done,
   output logic                ack_req_valid,
   input  logic                ack_req_ready,
   output logic [31:0]         ack_req_seq,
   output logic [WIN_BITS-1:0] ack_req_win,
   output logic                ack_req_fin
);

   localparam int unsigned TIMER_W = $clog2(DELAY_CYCLES + 1);
   localparam int unsigned CNT_W   = $clog2(SEGS_PER_ACK + 1);
   localparam logic [32:0] WIN_MAX = (33'd1 << WIN_BITS) - 33'd1;
   // With one segment per ACK, a restarted pending window is already full.
   localparam bit          ONE_SEG = (SEGS_PER_ACK == 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_REQ     = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     seg_cnt_q, seg_cnt_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [WIN_BITS-1:0]  last_win_q, last_win_d;
   logic                 more_q, more_d;
   logic                 urgent_q, urgent_d;
   logic                 fin_pend_q, fin_pend_d;
   logic                 valid_q, valid_d;
   logic [31:0]          seq_q, seq_d;
   logic [WIN_BITS-1:0]  win_q, win_d;
   logic                 fin_q, fin_d;

   logic [WIN_BITS-1:0]  win_c_s;
   logic [WIN_BITS-1:0]  win_diff_s;
   logic                 win_grow_s;
   logic                 fin_s;
   logic                 handshake_s;
   logic                 imm_trig_s;
   logic [CNT_W-1:0]     seg_cnt_inc_s;
   logic                 seg_full_s;
   logic                 timer_exp_s;
   logic                 urgent_any_s;
   logic                 more_any_s;
   logic                 capture_s;

   // Trigger decode shared by the next-state and datapath processes.
   always_comb begin
      if ({1'b0, window_size} > WIN_MAX) begin
         win_c_s = WIN_MAX[WIN_BITS-1:0];
      end else begin
         win_c_s = window_size[WIN_BITS-1:0];
      end
      win_diff_s    = win_c_s - last_win_q;
      // Only growth counts; a shrinking window never forces an update.
      win_grow_s    = ack_done && (win_c_s > last_win_q) &&
                      (win_diff_s >= WIN_BITS'(WIN_UPDATE_THRESH));
      fin_s         = fin_rx | fin_pend_q;
      handshake_s   = valid_q & ack_req_ready;
      imm_trig_s    = seg_ooo | fin_rx | win_grow_s;
      seg_cnt_inc_s = seg_cnt_q + CNT_W'(1);
      seg_full_s    = seg_rx && (seg_cnt_inc_s >= CNT_W'(SEGS_PER_ACK));
      // Timer holds the cycles left including the current one.
      timer_exp_s   = (timer_q <= TIMER_W'(1));
      urgent_any_s  = urgent_q | seg_ooo | fin_rx;
      more_any_s    = more_q | seg_rx;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (imm_trig_s || seg_full_s) begin
                  state_d = ST_REQ;
               end else if (seg_rx) begin
                  state_d = ST_PENDING;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PENDING: begin
               // Any immediate trigger or the timer yields one single request.
               if (imm_trig_s || seg_full_s || timer_exp_s) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_PENDING;
               end
            end
            ST_REQ: begin
               if (handshake_s) begin
                  if (urgent_any_s) begin
                     state_d = ST_REQ;
                  end else if (more_any_s) begin
                     state_d = ONE_SEG ? ST_REQ : ST_PENDING;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath and output next values.
   always_comb begin
      seg_cnt_d  = seg_cnt_q;
      timer_d    = timer_q;
      last_win_d = last_win_q;
      more_d     = more_q;
      urgent_d   = urgent_q;
      fin_pend_d = fin_pend_q;
      seq_d      = seq_q;
      win_d      = win_q;
      fin_d      = fin_q;
      valid_d    = 1'b0;
      // A fresh capture happens on entry to REQ or on a back-to-back reload.
      capture_s  = enable && (state_d == ST_REQ) &&
                   ((state_q != ST_REQ) || handshake_s);

      if (!enable) begin
         seg_cnt_d  = '0;
         timer_d    = '0;
         more_d     = 1'b0;
         urgent_d   = 1'b0;
         fin_pend_d = 1'b0;
         last_win_d = win_c_s;
      end else begin
         valid_d = (state_d == ST_REQ);
         case (state_q)
            ST_IDLE: begin
               if (seg_rx) begin
                  seg_cnt_d = CNT_W'(1);
                  timer_d   = TIMER_W'(DELAY_CYCLES);
               end else begin
                  seg_cnt_d = seg_cnt_q;
               end
            end
            ST_PENDING: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - TIMER_W'(1);
               end else begin
                  timer_d = '0;
               end
               if (seg_rx) begin
                  seg_cnt_d = seg_cnt_inc_s;
               end else begin
                  seg_cnt_d = seg_cnt_q;
               end
            end
            ST_REQ: begin
               if (handshake_s) begin
                  last_win_d = win_q;
                  seg_cnt_d  = '0;
                  fin_pend_d = 1'b0;
                  more_d     = 1'b0;
                  urgent_d   = 1'b0;
                  if (state_d == ST_PENDING) begin
                     seg_cnt_d = CNT_W'(1);
                     timer_d   = TIMER_W'(DELAY_CYCLES);
                  end else begin
                     timer_d   = timer_q;
                  end
               end else begin
                  more_d     = more_q | seg_rx;
                  urgent_d   = urgent_q | seg_ooo | fin_rx;
                  fin_pend_d = fin_pend_q | fin_rx;
               end
            end
            default: begin
               seg_cnt_d = '0;
            end
         endcase
         if (capture_s) begin
            seq_d = ack_out + {31'd0, fin_s};
            win_d = win_c_s;
            fin_d = fin_s;
         end else begin
            seq_d = seq_q;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, flags and registered request outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_cnt_q  <= '0;
         timer_q    <= '0;
         last_win_q <= '0;
         more_q     <= 1'b0;
         urgent_q   <= 1'b0;
         fin_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         seq_q      <= 32'd0;
         win_q      <= '0;
         fin_q      <= 1'b0;
      end else begin
         seg_cnt_q  <= seg_cnt_d;
         timer_q    <= timer_d;
         last_win_q <= last_win_d;
         more_q     <= more_d;
         urgent_q   <= urgent_d;
         fin_pend_q <= fin_pend_d;
         valid_q    <= valid_d;
         seq_q      <= seq_d;
         win_q      <= win_d;
         fin_q      <= fin_d;
      end
   end

   assign ack_req_valid = valid_q;
   assign ack_req_seq   = seq_q;
   assign ack_req_win   = win_q;
   assign ack_req_fin   = fin_q;

endmodule

// File: tb/tb_tcp_ack_scheduler.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for tcp_ack_scheduler with DELAY_CYCLES=10,
// SEGS_PER_ACK=2, WIN_UPDATE_THRESH=4, WIN_BITS=16.  Inputs are driven 1 ns
// after the rising edge; outputs are sampled at the same point, so a value
// observed after tick k reflects the k-th edge.
// ---------------------------------------------------------------------------
module tb_tcp_ack_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        seg_rx;
   logic        seg_ooo;
   logic        fin_rx;
   logic [31:0] ack_out;
   logic [31:0] window_size;
   logic        ack_done;
   logic        ack_req_valid;
   logic        ack_req_ready;
   logic [31:0] ack_req_seq;
   logic [15:0] ack_req_win;
   logic        ack_req_fin;

   int n_cmp;
   int n_bad;

   tcp_ack_scheduler #(
      .DELAY_CYCLES(10),
      .SEGS_PER_ACK(2),
      .WIN_UPDATE_THRESH(4),
      .WIN_BITS(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .seg_rx(seg_rx),
      .seg_ooo(seg_ooo),
      .fin_rx(fin_rx),
      .ack_out(ack_out),
      .window_size(window_size),
      .ack_done(ack_done),
      .ack_req_valid(ack_req_valid),
      .ack_req_ready(ack_req_ready),
      .ack_req_seq(ack_req_seq),
      .ack_req_win(ack_req_win),
      .ack_req_fin(ack_req_fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; seg_rx = 1'b0; seg_ooo = 1'b0; fin_rx = 1'b0;
      ack_out = 32'd0; window_size = 32'd100; ack_done = 1'b0; ack_req_ready = 1'b0;
      tick(); tick();
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'd0) begin n_bad++; $display("FAIL reset_seq: got %h want 0", ack_req_seq); end
      n_cmp++; if (ack_req_win !== 16'd0) begin n_bad++; $display("FAIL reset_win: got %h want 0", ack_req_win); end
      n_cmp++; if (ack_req_fin !== 1'b0) begin n_bad++; $display("FAIL reset_fin: got %b want 0", ack_req_fin); end
      rst_n = 1'b1;
      tick();
      enable = 1'b1;
      tick();
   endtask

   task automatic test_timeout();
      logic early;
      ack_out = 32'h0000_1000;
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      early = ack_req_valid;
      for (int i = 2; i <= 10; i++) begin
         tick();
         early = early | ack_req_valid;
      end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL timeout_early: valid seen before 11 cycles"); end
      tick();
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL timeout_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_1000) begin n_bad++; $display("FAIL timeout_seq: got %h want 00001000", ack_req_seq); end
      n_cmp++; if (ack_req_win !== 16'd100) begin n_bad++; $display("FAIL timeout_win: got %h want 0064", ack_req_win); end
      n_cmp++; if (ack_req_fin !== 1'b0) begin n_bad++; $display("FAIL timeout_fin: got %b want 0", ack_req_fin); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_handshake: got %b want 0", ack_req_valid); end
      early = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         early = early | ack_req_valid;
      end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: spurious request after handshake"); end
   endtask

   task automatic test_segs_per_ack();
      logic early;
      ack_out = 32'h0000_1100;
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      tick(); tick();
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL segs_first: got %b want 0", ack_req_valid); end
      ack_out = 32'h0000_1200;
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL segs_second_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_1200) begin n_bad++; $display("FAIL segs_seq: got %h want 00001200", ack_req_seq); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      // A single new segment must restart counting from zero, not trigger at once.
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      early = ack_req_valid;
      tick();
      early = early | ack_req_valid;
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL segs_cnt_cleared: request after one segment"); end
      enable = 1'b0; tick(); enable = 1'b1; tick();
   endtask

   task automatic test_back_to_back();
      int unstable;
      ack_out = 32'h0000_2000;
      seg_ooo = 1'b1; tick(); seg_ooo = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_2000) begin n_bad++; $display("FAIL ooo_seq: got %h want 00002000", ack_req_seq); end
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            seg_ooo = 1'b1; tick(); seg_ooo = 1'b0;
            ack_out = 32'h0000_2100;
         end else begin
            tick();
         end
         if (ack_req_valid !== 1'b1 || ack_req_seq !== 32'h0000_2000 || ack_req_win !== 16'd100)
            unstable++;
      end
      n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL hold_stable: %0d unstable cycles want 0", unstable); end
      ack_req_ready = 1'b1; tick();
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_2100) begin n_bad++; $display("FAIL b2b_seq: got %h want 00002100", ack_req_seq); end
      tick(); ack_req_ready = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got %b want 0", ack_req_valid); end
   endtask

   task automatic test_more_during_req();
      logic early;
      ack_out = 32'h0000_2200;
      seg_ooo = 1'b1; tick(); seg_ooo = 1'b0;
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      early = ack_req_valid;
      for (int i = 1; i <= 9; i++) begin
         tick();
         early = early | ack_req_valid;
      end
      n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL more_early: request before pending timeout"); end
      tick();
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL more_timeout: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_2200) begin n_bad++; $display("FAIL more_seq: got %h want 00002200", ack_req_seq); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
   endtask

   task automatic test_fin();
      ack_out = 32'h0000_3000;
      fin_rx = 1'b1; tick(); fin_rx = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL fin_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'h0000_3001) begin n_bad++; $display("FAIL fin_seq: got %h want 00003001", ack_req_seq); end
      n_cmp++; if (ack_req_fin !== 1'b1) begin n_bad++; $display("FAIL fin_flag: got %b want 1", ack_req_fin); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL fin_done: got %b want 0", ack_req_valid); end
   endtask

   task automatic test_window_update();
      window_size = 32'd2;
      enable = 1'b0; tick(); enable = 1'b1; tick();
      window_size = 32'd8;
      ack_done = 1'b1; tick(); ack_done = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL win8_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_win !== 16'd8) begin n_bad++; $display("FAIL win8_value: got %h want 0008", ack_req_win); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      window_size = 32'h0001_0000;
      ack_done = 1'b1; tick(); ack_done = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL winclamp_valid: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_win !== 16'hFFFF) begin n_bad++; $display("FAIL winclamp_value: got %h want ffff", ack_req_win); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      // Growth of 3 is below threshold, growth of 4 meets it.
      window_size = 32'd10;
      enable = 1'b0; tick(); enable = 1'b1; tick();
      window_size = 32'd13;
      ack_done = 1'b1; tick(); ack_done = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL win_below_thresh: got %b want 0", ack_req_valid); end
      window_size = 32'd14;
      ack_done = 1'b1; tick(); ack_done = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL win_at_thresh: got %b want 1", ack_req_valid); end
      n_cmp++; if (ack_req_win !== 16'd14) begin n_bad++; $display("FAIL win_at_thresh_value: got %h want 000e", ack_req_win); end
      ack_req_ready = 1'b1; tick(); ack_req_ready = 1'b0;
      window_size = 32'd100;
      enable = 1'b0; tick(); enable = 1'b1; tick();
   endtask

   task automatic test_enable_drop();
      logic seen;
      ack_out = 32'h0000_4000;
      seg_ooo = 1'b1; tick(); seg_ooo = 1'b0;
      n_cmp++; if (ack_req_valid !== 1'b1) begin n_bad++; $display("FAIL en_pre_valid: got %b want 1", ack_req_valid); end
      enable = 1'b0; tick();
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL en_drop_valid: got %b want 0", ack_req_valid); end
      enable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen = seen | ack_req_valid;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL en_reenable: request without trigger"); end
   endtask

   task automatic test_async_reset();
      ack_out = 32'h0000_5000;
      seg_rx = 1'b1; tick(); seg_rx = 1'b0;
      n_cmp++; if (ack_req_seq !== 32'h0000_4000) begin n_bad++; $display("FAIL arst_pre_seq: got %h want 00004000", ack_req_seq); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (ack_req_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", ack_req_valid); end
      n_cmp++; if (ack_req_seq !== 32'd0) begin n_bad++; $display("FAIL arst_seq: got %h want 0", ack_req_seq); end
      n_cmp++; if (ack_req_win !== 16'd0) begin n_bad++; $display("FAIL arst_win: got %h want 0", ack_req_win); end
      n_cmp++; if (ack_req_fin !== 1'b0) begin n_bad++; $display("FAIL arst_fin: got %b want 0", ack_req_fin); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_timeout();
      test_segs_per_ack();
      test_back_to_back();
      test_more_during_req();
      test_fin();
      test_window_update();
      test_enable_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
